// File: rtl/cmsdk_haddr_trace_buf_pkg.sv
// Shared definitions for the HADDR trace buffer: record layout, default widths
// and the saturating drop-counter helper.
package cmsdk_haddr_trace_buf_pkg;

  localparam int ADDR_W        = 32;
  localparam int TSW_DEF       = 16;
  localparam int DROP_CNT_W    = 8;
  localparam int REC_ADDR_LSB  = 0;
  localparam int REC_DELTA_LSB = ADDR_W;

  function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cmsdk_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with explicit occupancy count.
// A write into a full FIFO is accepted only when a read retires the head in the same cycle.
module cmsdk_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          do_wr;
  logic          do_rd;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LW'(DEPTH));
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign level = level_reg;

  // Head is forced to zero while empty so stale or uninitialised storage never shows.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/cmsdk_haddr_trace_buf.sv
// Logs {delta-time, address} records whenever the monitored AHB address changes
// inside the configured window; records drain over a valid/ready stream.
module cmsdk_haddr_trace_buf
  import cmsdk_haddr_trace_buf_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] WIN_BASE = 32'h0000_0000,
  parameter logic [31:0] WIN_MASK = 32'h0000_0000,
  parameter int          TSW      = TSW_DEF
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [ADDR_W-1:0]         haddr_mon,
  input  logic                      trace_en,
  output logic                      trc_valid,
  output logic [ADDR_W+TSW-1:0]     trc_data,
  input  logic                      trc_ready,
  output logic                      ovf,
  input  logic                      ovf_clr,
  output logic [DROP_CNT_W-1:0]     drop_cnt,
  output logic [$clog2(DEPTH):0]    level
);

  logic [ADDR_W-1:0]     prev_addr_reg;
  logic                  prev_vld_reg;
  logic [TSW-1:0]        ts_cnt_reg;
  logic                  ovf_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  logic                  in_window;
  logic                  evt;
  logic                  pop;
  logic                  accept;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_W+TSW-1:0] rec_next;

  assign in_window = ((haddr_mon & WIN_MASK) == WIN_BASE);
  // A fresh enable (prev_vld low) forces an event even if the address did not move.
  assign evt       = trace_en & in_window & (~prev_vld_reg | (haddr_mon != prev_addr_reg));
  assign pop       = trc_valid & trc_ready;
  assign accept    = evt & (~fifo_full | pop);
  assign drop      = evt & fifo_full & ~pop;

  always_comb begin
    rec_next = '0;
    rec_next[REC_DELTA_LSB +: TSW]   = ts_cnt_reg;
    rec_next[REC_ADDR_LSB  +: ADDR_W] = haddr_mon;
  end

  cmsdk_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + TSW)
  ) u_fifo (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .wr_en   (evt),
    .wr_data (rec_next),
    .full    (fifo_full),
    .rd_en   (trc_ready),
    .rd_data (trc_data),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign trc_valid = ~fifo_empty;
  assign ovf       = ovf_reg;
  assign drop_cnt  = drop_cnt_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prev_addr_reg <= '0;
      prev_vld_reg  <= 1'b0;
    end else begin
      prev_addr_reg <= haddr_mon;
      prev_vld_reg  <= trace_en;
    end
  end

  // A dropped record does not reload the delta, so the next record spans the gap.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ts_cnt_reg <= TSW'(1);
    end else if (trace_en) begin
      if (accept) begin
        ts_cnt_reg <= TSW'(1);
      end else if (~&ts_cnt_reg) begin
        ts_cnt_reg <= ts_cnt_reg + TSW'(1);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovf_reg      <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      ovf_reg      <= 1'b1;
      drop_cnt_reg <= ovf_clr ? DROP_CNT_W'(1) : drop_sat_inc(drop_cnt_reg);
    end else if (ovf_clr) begin
      ovf_reg      <= 1'b0;
      drop_cnt_reg <= '0;
    end
  end

endmodule

// File: tb/tb_cmsdk_haddr_trace_buf.sv
// Directed plus randomized bench for cmsdk_haddr_trace_buf, checked every cycle
// against a queue-based model of the trace buffer.
module tb_cmsdk_haddr_trace_buf;

  localparam int          DEPTH  = 4;
  localparam int          TSW    = 12;
  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam logic [31:0] MASK   = 32'hFFFF_0000;
  localparam int          TS_MAX = (1 << TSW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       haddr_mon = '0;
  logic              trace_en = 1'b0;
  logic              trc_valid;
  logic [TSW+31:0]   trc_data;
  logic              trc_ready = 1'b0;
  logic              ovf;
  logic              ovf_clr = 1'b0;
  logic [7:0]        drop_cnt;
  logic [2:0]        level;

  int total = 0;
  int bad   = 0;

  cmsdk_haddr_trace_buf #(
    .DEPTH    (DEPTH),
    .WIN_BASE (BASE),
    .WIN_MASK (MASK),
    .TSW      (TSW)
  ) dut (
    .HCLK      (clk),
    .HRESETn   (rst_n),
    .haddr_mon (haddr_mon),
    .trace_en  (trace_en),
    .trc_valid (trc_valid),
    .trc_data  (trc_data),
    .trc_ready (trc_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [TSW+31:0] m_q[$];
  bit              m_ovf = 0;
  int              m_drop = 0;
  logic [31:0]     m_prev_addr = '0;
  bit              m_prev_vld = 0;
  int              m_ts = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 0;
      m_drop = 0;
      m_prev_addr = '0;
      m_prev_vld = 0;
      m_ts = 1;
    end else begin
      bit evt;
      bit pop;
      bit full;
      bit acc;
      logic [TSW-1:0] ts_l;
      evt  = trace_en && ((haddr_mon & MASK) == BASE) && (!m_prev_vld || haddr_mon != m_prev_addr);
      pop  = (m_q.size() > 0) && trc_ready;
      full = (m_q.size() == DEPTH);
      acc  = evt && (!full || pop);
      ts_l = m_ts[TSW-1:0];
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back({ts_l, haddr_mon});
      if (evt && !acc) begin
        m_ovf  = 1;
        m_drop = ovf_clr ? 1 : ((m_drop >= 255) ? 255 : m_drop + 1);
      end else if (ovf_clr) begin
        m_ovf  = 0;
        m_drop = 0;
      end
      if (trace_en) m_ts = acc ? 1 : ((m_ts >= TS_MAX) ? TS_MAX : m_ts + 1);
      m_prev_addr = haddr_mon;
      m_prev_vld  = trace_en;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("valid", {63'd0, trc_valid}, {63'd0, m_q.size() > 0});
    chk("level", {61'd0, level}, 64'(m_q.size()));
    chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
    chk("drop_cnt", {56'd0, drop_cnt}, 64'(m_drop));
    if (m_q.size() > 0) begin
      chk("data", {20'd0, trc_data}, {20'd0, m_q[0]});
      if (trc_ready)
        $display("pop delta=%0d addr=%08h level=%0d", trc_data[TSW+31:32], trc_data[31:0], level);
    end
  end

  task automatic step(input logic [31:0] a, input logic e, input logic r);
    haddr_mon = a;
    trace_en  = e;
    trc_ready = r;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i <= DEPTH; i++) step(haddr_mon, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_addr [4];
  logic [31:0] pool [4];

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, trc_valid}, 64'd0);
    chk("rst_data", {20'd0, trc_data}, 64'd0);
    chk("rst_level", {61'd0, level}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_drop", {56'd0, drop_cnt}, 64'd0);
    rst_n = 1'b1;

    // First record delta 1, then delta 3 after three cycles on the same address
    step(32'h2000_0100, 1'b1, 1'b0);
    chk("t1_rec0", {20'd0, trc_data}, {20'd0, 12'd1, 32'h2000_0100});
    step(32'h2000_0100, 1'b1, 1'b0);
    step(32'h2000_0100, 1'b1, 1'b0);
    step(32'h2000_0104, 1'b1, 1'b0);
    chk("t1_level", {61'd0, level}, 64'd2);
    step(32'h2000_0104, 1'b0, 1'b1);
    chk("t1_rec1", {20'd0, trc_data}, {20'd0, 12'd3, 32'h2000_0104});
    step(32'h2000_0104, 1'b0, 1'b1);
    chk("t1_empty", {61'd0, level}, 64'd0);

    // Window filter
    step(32'h0000_0010, 1'b1, 1'b1);
    chk("t2_outside", {61'd0, level}, 64'd0);
    step(32'h2000_0010, 1'b1, 1'b1);
    chk("t2_inside", {20'd0, trc_data}, {20'd0, 12'd2, 32'h2000_0010});
    step(32'h2000_0010, 1'b0, 1'b1);

    // Overflow: 6 distinct addresses into a 4-deep FIFO
    for (int i = 0; i < 6; i++) step(32'h2000_1000 + 32'(4 * i), 1'b1, 1'b0);
    chk("t3_level", {61'd0, level}, 64'd4);
    chk("t3_ovf", {63'd0, ovf}, 64'd1);
    chk("t3_drop", {56'd0, drop_cnt}, 64'd2);
    chk("t3_head", {20'd0, trc_data}, {20'd0, 12'd1, 32'h2000_1000});

    // Full with simultaneous push and pop
    step(32'h2000_2000, 1'b1, 1'b1);
    chk("t4_level", {61'd0, level}, 64'd4);
    chk("t4_drop", {56'd0, drop_cnt}, 64'd2);
    exp_addr[0] = 32'h2000_1004;
    exp_addr[1] = 32'h2000_1008;
    exp_addr[2] = 32'h2000_100C;
    exp_addr[3] = 32'h2000_2000;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", {32'd0, trc_data[31:0]}, {32'd0, exp_addr[i]});
      if (i == 3) chk("t4_gap_delta", {52'd0, trc_data[TSW+31:32]}, 64'd3);
      step(32'h2000_2000, 1'b0, 1'b1);
    end
    chk("t3_drained", {61'd0, level}, 64'd0);
    ovf_clr = 1'b1;
    step(32'h2000_2000, 1'b0, 1'b0);
    chk("clr_ovf", {63'd0, ovf}, 64'd0);
    chk("clr_drop", {56'd0, drop_cnt}, 64'd0);

    // drop_cnt saturation, then clear and drop in the same cycle
    for (int i = 0; i < 262; i++) step(32'h2000_3000 + 32'(4 * (i % 2)), 1'b1, 1'b0);
    chk("sat_drop", {56'd0, drop_cnt}, 64'hFF);
    ovf_clr = 1'b1;
    step(32'h2000_3008, 1'b1, 1'b0);
    chk("clr_drop_ovf", {63'd0, ovf}, 64'd1);
    chk("clr_drop_cnt", {56'd0, drop_cnt}, 64'd1);
    ovf_clr = 1'b1;
    step(32'h2000_3008, 1'b0, 1'b0);
    drain();

    // Delta saturation with a held address
    for (int i = 0; i < TS_MAX + 100; i++) step(32'h2000_5000, 1'b1, 1'b1);
    step(32'h2000_5004, 1'b1, 1'b0);
    chk("t5_sat_delta", {20'd0, trc_data}, {20'd0, 12'hFFF, 32'h2000_5004});
    drain();

    // Asynchronous reset mid-drain
    for (int i = 0; i < 4; i++) step(32'h2000_6000 + 32'(4 * i), 1'b1, 1'b0);
    step(32'h2000_600C, 1'b0, 1'b1);
    chk("t6_level3", {61'd0, level}, 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {63'd0, trc_valid}, 64'd0);
    chk("t6_async_level", {61'd0, level}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(32'h2000_7000, 1'b1, 1'b0);
    chk("t6_first", {20'd0, trc_data}, {20'd0, 12'd1, 32'h2000_7000});
    drain();

    // Randomized traffic
    pool[0] = 32'h2000_0040;
    pool[1] = 32'h2000_0044;
    pool[2] = 32'h0000_0040;
    pool[3] = 32'h2001_0048;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 2) == 0) ? haddr_mon : pool[$urandom_range(0, 3)];
      ovf_clr = ($urandom_range(0, 30) == 0);
      step(a, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
